// File: rtl/axi_rr_arbiter_if.sv
// Bundle of every handshake and payload signal around axi_rr_arbiter.
// m_* signals face the CPU cores (flattened, master i in slice i), s_* signals
// face the xbar. The arbiter connects through the "master" modport; whatever
// sits on the other side of both buses (cores and xbar) uses "slave".
interface axi_rr_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int IW = 4
) ();
  localparam int SW = DW / 8;

  // core side, read
  logic [NM-1:0]    m_arvalid, m_arready;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*IW-1:0] m_arid;
  logic [NM*8-1:0]  m_arlen;
  logic [NM*3-1:0]  m_arsize;
  logic [NM*2-1:0]  m_arburst;
  logic [NM-1:0]    m_rvalid, m_rready;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast;
  logic [IW-1:0]    m_rid;
  // core side, write
  logic [NM-1:0]    m_awvalid, m_awready;
  logic [NM*AW-1:0] m_awaddr;
  logic [NM*IW-1:0] m_awid;
  logic [NM*8-1:0]  m_awlen;
  logic [NM*3-1:0]  m_awsize;
  logic [NM*2-1:0]  m_awburst;
  logic [NM-1:0]    m_wvalid, m_wready;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [NM-1:0]    m_wlast;
  logic [NM-1:0]    m_bvalid, m_bready;
  logic [1:0]       m_bresp;
  logic [IW-1:0]    m_bid;
  // xbar side
  logic             s_arvalid, s_arready;
  logic [AW-1:0]    s_araddr;
  logic [IW-1:0]    s_arid;
  logic [7:0]       s_arlen;
  logic [2:0]       s_arsize;
  logic [1:0]       s_arburst;
  logic             s_rvalid, s_rready;
  logic [DW-1:0]    s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rlast;
  logic [IW-1:0]    s_rid;
  logic             s_awvalid, s_awready;
  logic [AW-1:0]    s_awaddr;
  logic [IW-1:0]    s_awid;
  logic [7:0]       s_awlen;
  logic [2:0]       s_awsize;
  logic [1:0]       s_awburst;
  logic             s_wvalid, s_wready;
  logic [DW-1:0]    s_wdata;
  logic [SW-1:0]    s_wstrb;
  logic             s_wlast;
  logic             s_bvalid, s_bready;
  logic [1:0]       s_bresp;
  logic [IW-1:0]    s_bid;
  // current owners
  logic [NM-1:0]    rd_grant, wr_grant;

  modport master (
    input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
    input  m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_bid,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output m_awready, m_wready, m_bvalid, m_bresp, m_bid,
    output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
    output s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    output rd_grant, wr_grant
  );

  modport slave (
    output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
    output m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
    output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    output s_awready, s_wready, s_bvalid, s_bresp, s_bid,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_bid,
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
    input  s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    input  rd_grant, wr_grant
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter. Read and write paths arbitrate and run
// independently; each path stays locked to one master for a whole burst
// (AR..R-last, AW..W-last..B). After a grant everything is combinational
// passthrough, so there is no buffering and one bubble between bursts.
// Build option: define AXI_ARB_RR_EN for round-robin selection; without it
// selection is fixed priority (lowest index wins) and no pointer flops exist.
module axi_rr_arbiter #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int IW = 4
) (
  input logic              clk,
  input logic              reset,
  axi_rr_arbiter_if.master bus
);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  rd_state_t     r_rd_state, w_rd_state_nx;
  wr_state_t     r_wr_state, w_wr_state_nx;
  logic [NM-1:0] r_rd_grant, w_rd_grant_nx, w_rd_pick;
  logic [NM-1:0] r_wr_grant, w_wr_grant_nx, w_wr_pick;

  logic          w_s_arvalid, w_s_rready, w_s_awvalid, w_s_wvalid, w_s_wlast, w_s_bready;
  logic [AW-1:0] w_s_araddr, w_s_awaddr;
  logic [IW-1:0] w_s_arid, w_s_awid;
  logic [7:0]    w_s_arlen, w_s_awlen;
  logic [2:0]    w_s_arsize, w_s_awsize;
  logic [1:0]    w_s_arburst, w_s_awburst;
  logic [DW-1:0] w_s_wdata;
  logic [SW-1:0] w_s_wstrb;

`ifdef AXI_ARB_RR_EN
  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  logic [PW-1:0] r_rd_ptr, r_wr_ptr;

  // First requester at or after (last + 1), wrapping around.
  function automatic logic [NM-1:0] f_pick(input logic [NM-1:0] req, input logic [PW-1:0] last);
    logic [NM-1:0] g;
    logic          found;
    int            idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(last) + k) % NM;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] f_index(input logic [NM-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  assign w_rd_pick = f_pick(bus.m_arvalid, r_rd_ptr);
  assign w_wr_pick = f_pick(bus.m_awvalid, r_wr_ptr);

  // Remember the last winner of each path; only moves when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= PW'(NM - 1);
      r_wr_ptr <= PW'(NM - 1);
    end else begin
      if (r_rd_state == RD_IDLE && |bus.m_arvalid) r_rd_ptr <= f_index(w_rd_pick);
      if (r_wr_state == WR_IDLE && |bus.m_awvalid) r_wr_ptr <= f_index(w_wr_pick);
    end
  end
`else
  // Lowest-index requester wins.
  function automatic logic [NM-1:0] f_pick(input logic [NM-1:0] req);
    logic [NM-1:0] g;
    logic          found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && req[i]) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign w_rd_pick = f_pick(bus.m_arvalid);
  assign w_wr_pick = f_pick(bus.m_awvalid);
`endif

  // State and owner registers of both paths.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
      r_wr_state <= WR_IDLE;
      r_rd_grant <= '0;
      r_wr_grant <= '0;
    end else begin
      r_rd_state <= w_rd_state_nx;
      r_wr_state <= w_wr_state_nx;
      r_rd_grant <= w_rd_grant_nx;
      r_wr_grant <= w_wr_grant_nx;
    end
  end

  // Read path sequencing: grant in IDLE, AR handshake, R beats until rlast.
  always_comb begin
    w_rd_state_nx = r_rd_state;
    w_rd_grant_nx = r_rd_grant;
    case (r_rd_state)
      RD_IDLE: begin
        if (|bus.m_arvalid) begin
          w_rd_grant_nx = w_rd_pick;
          w_rd_state_nx = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (w_s_arvalid && bus.s_arready) w_rd_state_nx = RD_DATA;
      end
      RD_DATA: begin
        if (bus.s_rvalid && w_s_rready && bus.s_rlast) begin
          w_rd_state_nx = RD_IDLE;
          w_rd_grant_nx = '0;
        end
      end
      default: begin
        w_rd_state_nx = RD_IDLE;
        w_rd_grant_nx = '0;
      end
    endcase
  end

  // Write path sequencing: grant, AW handshake, W beats until wlast, then B.
  always_comb begin
    w_wr_state_nx = r_wr_state;
    w_wr_grant_nx = r_wr_grant;
    case (r_wr_state)
      WR_IDLE: begin
        if (|bus.m_awvalid) begin
          w_wr_grant_nx = w_wr_pick;
          w_wr_state_nx = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (w_s_awvalid && bus.s_awready) w_wr_state_nx = WR_DATA;
      end
      WR_DATA: begin
        if (w_s_wvalid && bus.s_wready && w_s_wlast) w_wr_state_nx = WR_RESP;
      end
      WR_RESP: begin
        if (bus.s_bvalid && w_s_bready) begin
          w_wr_state_nx = WR_IDLE;
          w_wr_grant_nx = '0;
        end
      end
      default: begin
        w_wr_state_nx = WR_IDLE;
        w_wr_grant_nx = '0;
      end
    endcase
  end

  // Select the owner's address and write-data fields (grant is one-hot or zero).
  always_comb begin
    w_s_araddr  = '0;
    w_s_arid    = '0;
    w_s_arlen   = '0;
    w_s_arsize  = '0;
    w_s_arburst = '0;
    w_s_awaddr  = '0;
    w_s_awid    = '0;
    w_s_awlen   = '0;
    w_s_awsize  = '0;
    w_s_awburst = '0;
    w_s_wdata   = '0;
    w_s_wstrb   = '0;
    w_s_wlast   = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (r_rd_grant[i]) begin
        w_s_araddr  = bus.m_araddr[i*AW +: AW];
        w_s_arid    = bus.m_arid[i*IW +: IW];
        w_s_arlen   = bus.m_arlen[i*8 +: 8];
        w_s_arsize  = bus.m_arsize[i*3 +: 3];
        w_s_arburst = bus.m_arburst[i*2 +: 2];
      end
      if (r_wr_grant[i]) begin
        w_s_awaddr  = bus.m_awaddr[i*AW +: AW];
        w_s_awid    = bus.m_awid[i*IW +: IW];
        w_s_awlen   = bus.m_awlen[i*8 +: 8];
        w_s_awsize  = bus.m_awsize[i*3 +: 3];
        w_s_awburst = bus.m_awburst[i*2 +: 2];
        w_s_wdata   = bus.m_wdata[i*DW +: DW];
        w_s_wstrb   = bus.m_wstrb[i*SW +: SW];
        w_s_wlast   = bus.m_wlast[i];
      end
    end
  end

  // Valids/readies are gated by state so nothing leaks outside its phase;
  // early W beats therefore wait with wready low until WDATA.
  assign w_s_arvalid = (r_rd_state == RD_ADDR) && |(bus.m_arvalid & r_rd_grant);
  assign w_s_rready  = (r_rd_state == RD_DATA) && |(bus.m_rready & r_rd_grant);
  assign w_s_awvalid = (r_wr_state == WR_ADDR) && |(bus.m_awvalid & r_wr_grant);
  assign w_s_wvalid  = (r_wr_state == WR_DATA) && |(bus.m_wvalid & r_wr_grant);
  assign w_s_bready  = (r_wr_state == WR_RESP) && |(bus.m_bready & r_wr_grant);

  assign bus.m_arready = (r_rd_state == RD_ADDR && bus.s_arready) ? r_rd_grant : '0;
  assign bus.m_rvalid  = (r_rd_state == RD_DATA && bus.s_rvalid) ? r_rd_grant : '0;
  assign bus.m_awready = (r_wr_state == WR_ADDR && bus.s_awready) ? r_wr_grant : '0;
  assign bus.m_wready  = (r_wr_state == WR_DATA && bus.s_wready) ? r_wr_grant : '0;
  assign bus.m_bvalid  = (r_wr_state == WR_RESP && bus.s_bvalid) ? r_wr_grant : '0;

  assign bus.m_rdata = bus.s_rdata;
  assign bus.m_rresp = bus.s_rresp;
  assign bus.m_rlast = bus.s_rlast;
  assign bus.m_rid   = bus.s_rid;
  assign bus.m_bresp = bus.s_bresp;
  assign bus.m_bid   = bus.s_bid;

  assign bus.s_arvalid = w_s_arvalid;
  assign bus.s_araddr  = w_s_araddr;
  assign bus.s_arid    = w_s_arid;
  assign bus.s_arlen   = w_s_arlen;
  assign bus.s_arsize  = w_s_arsize;
  assign bus.s_arburst = w_s_arburst;
  assign bus.s_rready  = w_s_rready;
  assign bus.s_awvalid = w_s_awvalid;
  assign bus.s_awaddr  = w_s_awaddr;
  assign bus.s_awid    = w_s_awid;
  assign bus.s_awlen   = w_s_awlen;
  assign bus.s_awsize  = w_s_awsize;
  assign bus.s_awburst = w_s_awburst;
  assign bus.s_wvalid  = w_s_wvalid;
  assign bus.s_wdata   = w_s_wdata;
  assign bus.s_wstrb   = w_s_wstrb;
  assign bus.s_wlast   = w_s_wlast;
  assign bus.s_bready  = w_s_bready;

  assign bus.rd_grant = r_rd_grant;
  assign bus.wr_grant = r_wr_grant;
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Self-checking bench for axi_rr_arbiter with three masters: an arbitration
// table, directed multi-cycle sequences and a randomized read-path run
// compared against a transaction-level owner model.
module tb_axi_rr_arbiter;
  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW), .IW(IW)) bus ();
  axi_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .IW(IW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  logic [AW-1:0] ar_addr[NM];
  logic [7:0]    ar_len[NM];

  typedef struct {
    logic [NM-1:0] req;
    logic [NM-1:0] gnt;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_arvalid = '0; bus.m_araddr = '0; bus.m_arid = '0; bus.m_arlen = '0;
    bus.m_arsize = '0; bus.m_arburst = '0; bus.m_rready = '0;
    bus.m_awvalid = '0; bus.m_awaddr = '0; bus.m_awid = '0; bus.m_awlen = '0;
    bus.m_awsize = '0; bus.m_awburst = '0;
    bus.m_wvalid = '0; bus.m_wdata = '0; bus.m_wstrb = '0; bus.m_wlast = '0; bus.m_bready = '0;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0; bus.s_rresp = '0;
    bus.s_rlast = 1'b0; bus.s_rid = '0; bus.s_awready = 1'b0; bus.s_wready = 1'b0;
    bus.s_bvalid = 1'b0; bus.s_bresp = '0; bus.s_bid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ar(input int m, input logic [AW-1:0] a, input logic [7:0] len, input logic [IW-1:0] id);
    bus.m_arvalid[m] = 1'b1;
    bus.m_araddr[m*AW +: AW] = a;
    bus.m_arlen[m*8 +: 8] = len;
    bus.m_arid[m*IW +: IW] = id;
    bus.m_arsize[m*3 +: 3] = 3'd2;
    bus.m_arburst[m*2 +: 2] = 2'b01;
    ar_addr[m] = a;
    ar_len[m] = len;
  endtask

  task automatic set_aw(input int m, input logic [AW-1:0] a, input logic [7:0] len, input logic [IW-1:0] id);
    bus.m_awvalid[m] = 1'b1;
    bus.m_awaddr[m*AW +: AW] = a;
    bus.m_awlen[m*8 +: 8] = len;
    bus.m_awid[m*IW +: IW] = id;
    bus.m_awsize[m*3 +: 3] = 3'd2;
    bus.m_awburst[m*2 +: 2] = 2'b01;
  endtask

  // Reference arbitration rule: next requester after the last winner, or lowest index.
  function automatic int model_pick(input logic [NM-1:0] req, input int last);
    int r;
    r = -1;
`ifdef AXI_ARB_RR_EN
    for (int k = NM; k >= 1; k--) if (req[(last + k) % NM]) r = (last + k) % NM;
`else
    for (int i = NM - 1; i >= 0; i--) if (req[i]) r = i + 0 * last;
`endif
    return r;
  endfunction

  initial begin
    logic [AW-1:0] ea;
    logic [NM-1:0] exp_g, hs;
    logic [NM-1:0] seq_req;
    int            own, model_last, sl_beats, win;
    bit            ar_done, accept, rhs;
    logic [7:0]    acc_len;

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 1'b1;
    #2;
    bus.m_arvalid = '1; bus.m_awvalid = '1; bus.m_wvalid = '1;
    bus.m_rready = '1; bus.m_bready = '1;
    bus.s_arready = 1'b1; bus.s_awready = 1'b1; bus.s_wready = 1'b1;
    bus.s_rvalid = 1'b1; bus.s_bvalid = 1'b1;
    tick();
    check("rst_m_arready", bus.m_arready, 0);
    check("rst_m_awready", bus.m_awready, 0);
    check("rst_m_wready", bus.m_wready, 0);
    check("rst_m_rvalid", bus.m_rvalid, 0);
    check("rst_m_bvalid", bus.m_bvalid, 0);
    check("rst_s_arvalid", bus.s_arvalid, 0);
    check("rst_s_awvalid", bus.s_awvalid, 0);
    check("rst_s_wvalid", bus.s_wvalid, 0);
    check("rst_s_rready", bus.s_rready, 0);
    check("rst_s_bready", bus.s_bready, 0);
    check("rst_rd_grant", bus.rd_grant, 0);
    check("rst_wr_grant", bus.wr_grant, 0);
    // stray slave responses in IDLE must not be accepted
    bus.m_arvalid = '0; bus.m_awvalid = '0; bus.m_wvalid = '0;
    reset = 1'b0;
    tick();
    check("idle_s_rready", bus.s_rready, 0);
    check("idle_s_bready", bus.s_bready, 0);
    check("idle_m_rvalid", bus.m_rvalid, 0);
    check("idle_m_bvalid", bus.m_bvalid, 0);

    // ---------------- first arbitration from reset ----------------
    tbl[0] = '{req: 3'b001, gnt: 3'b001};
    tbl[1] = '{req: 3'b010, gnt: 3'b010};
    tbl[2] = '{req: 3'b110, gnt: 3'b010};
    tbl[3] = '{req: 3'b100, gnt: 3'b100};
    tbl[4] = '{req: 3'b111, gnt: 3'b001};
    tbl[5] = '{req: 3'b101, gnt: 3'b001};
    tbl[6] = '{req: 3'b000, gnt: 3'b000};
    for (int k = 0; k < 7; k++) begin
      do_reset();
      for (int m = 0; m < NM; m++) begin
        if (tbl[k].req[m]) begin
          set_ar(m, AW'(16'h1000 + m * 16'h100), 8'd0, IW'(m));
          set_aw(m, AW'(16'h2000 + m * 16'h100), 8'd0, IW'(m));
        end
      end
      #1;
      check("tbl_idle_s_arvalid", bus.s_arvalid, 0);
      check("tbl_idle_rd_grant", bus.rd_grant, 0);
      tick();
      check("tbl_rd_grant", bus.rd_grant, tbl[k].gnt);
      check("tbl_wr_grant", bus.wr_grant, tbl[k].gnt);
      check("tbl_s_arvalid", bus.s_arvalid, |tbl[k].req);
      check("tbl_s_awvalid", bus.s_awvalid, |tbl[k].req);
      check("tbl_m_arready_lo", bus.m_arready, 0);
      bus.s_arready = 1'b1;
      bus.s_awready = 1'b1;
      #1;
      check("tbl_m_arready", bus.m_arready, tbl[k].gnt);
      check("tbl_m_awready", bus.m_awready, tbl[k].gnt);
      if (|tbl[k].req) begin
        ea = '0;
        for (int m = 0; m < NM; m++) if (tbl[k].gnt[m]) ea = AW'(16'h1000 + m * 16'h100);
        check("tbl_s_araddr", bus.s_araddr, ea);
        check("tbl_s_awaddr", bus.s_awaddr, ea + AW'(16'h1000));
      end
    end

    // ---------------- concurrent paths with R backpressure ----------------
    do_reset();
    set_ar(0, 16'h0A00, 8'd3, 4'h5);
    set_aw(1, 16'h0B00, 8'd1, 4'h6);
    bus.s_arready = 1'b1;
    bus.s_awready = 1'b1;
    tick();
    check("cc_s_arvalid", bus.s_arvalid, 1);
    check("cc_s_awvalid", bus.s_awvalid, 1);
    check("cc_s_araddr", bus.s_araddr, 16'h0A00);
    check("cc_s_arlen", bus.s_arlen, 3);
    check("cc_s_awaddr", bus.s_awaddr, 16'h0B00);
    check("cc_s_awid", bus.s_awid, 6);
    check("cc_m_arready", bus.m_arready, 3'b001);
    check("cc_m_awready", bus.m_awready, 3'b010);
    tick();
    bus.m_arvalid = '0;
    bus.m_awvalid = '0;
    bus.m_rready[0] = 1'b1;
    bus.s_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata = DW'(32'hD0 + b);
      bus.s_rlast = (b == 3);
      bus.s_rid = 4'h5;
      bus.m_wvalid[1] = (b < 2);
      bus.m_wdata[DW +: DW] = DW'(32'hE0 + b);
      bus.m_wlast[1] = (b == 1);
      if (b == 2) begin
        bus.m_rready[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check("bp_s_rready", bus.s_rready, 0);
          check("bp_rd_grant", bus.rd_grant, 3'b001);
          check("bp_m_rdata", bus.m_rdata, 32'hD2);
          tick();
        end
        bus.m_rready[0] = 1'b1;
      end
      #1;
      check("cc_m_rvalid", bus.m_rvalid, 3'b001);
      check("cc_m_rdata", bus.m_rdata, 32'hD0 + b);
      check("cc_m_rlast", bus.m_rlast, (b == 3));
      check("cc_s_rready", bus.s_rready, 1);
      if (b < 2) begin
        check("cc_s_wvalid", bus.s_wvalid, 1);
        check("cc_s_wdata", bus.s_wdata, 32'hE0 + b);
        check("cc_s_wlast", bus.s_wlast, (b == 1));
        check("cc_m_wready", bus.m_wready, 3'b010);
      end
      tick();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast = 1'b0;
    #1;
    check("cc_rd_turnaround", bus.rd_grant, 0);
    bus.s_bvalid = 1'b1;
    bus.s_bid = 4'h6;
    bus.s_bresp = 2'b10;
    bus.m_bready[1] = 1'b1;
    #1;
    check("cc_m_bvalid", bus.m_bvalid, 3'b010);
    check("cc_m_bid", bus.m_bid, 6);
    check("cc_m_bresp", bus.m_bresp, 2'b10);
    check("cc_s_bready", bus.s_bready, 1);
    tick();
    bus.s_bvalid = 1'b0;
    #1;
    check("cc_wr_turnaround", bus.wr_grant, 0);

    // ---------------- reset in RDATA at beat 2 of 4 ----------------
    do_reset();
    set_ar(1, 16'h0C00, 8'd3, 4'h2);
    bus.s_arready = 1'b1;
    tick();
    tick();
    bus.m_arvalid = '0;
    bus.m_rready[1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata = DW'(32'hC0 + b);
      tick();
    end
    bus.s_rvalid = 1'b1;
    #1;
    check("mr_m_rvalid_pre", bus.m_rvalid, 3'b010);
    reset = 1'b1;
    #1;
    check("mr_m_rvalid", bus.m_rvalid, 0);
    check("mr_s_rready", bus.s_rready, 0);
    check("mr_rd_grant", bus.rd_grant, 0);
    tick();
    reset = 1'b0;
    bus.s_rvalid = 1'b0;
    set_ar(0, 16'h0E00, 8'd0, 4'h1);
    tick();
    check("mr_regrant", bus.rd_grant, 3'b001);
    check("mr_s_araddr", bus.s_araddr, 16'h0E00);

    // ---------------- early W ----------------
    do_reset();
    bus.s_wready = 1'b1;
    bus.m_wvalid[1] = 1'b1;
    bus.m_wdata[DW +: DW] = 32'hF0;
    bus.m_wlast[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("ew_m_wready_pre", bus.m_wready, 0);
      check("ew_s_wvalid_pre", bus.s_wvalid, 0);
      tick();
    end
    set_aw(1, 16'h0D00, 8'd1, 4'h3);
    bus.s_awready = 1'b1;
    tick();
    check("ew_s_awvalid", bus.s_awvalid, 1);
    check("ew_m_wready_addr", bus.m_wready, 0);
    check("ew_s_wvalid_addr", bus.s_wvalid, 0);
    tick();
    bus.m_awvalid = '0;
    #1;
    check("ew_m_wready0", bus.m_wready, 3'b010);
    check("ew_s_wdata0", bus.s_wdata, 32'hF0);
    tick();
    bus.m_wdata[DW +: DW] = 32'hF1;
    bus.m_wlast[1] = 1'b1;
    #1;
    check("ew_s_wdata1", bus.s_wdata, 32'hF1);
    check("ew_s_wlast1", bus.s_wlast, 1);
    tick();
    bus.m_wvalid = '0;
    #1;
    check("ew_m_wready_resp", bus.m_wready, 0);
    check("ew_wr_grant_resp", bus.wr_grant, 3'b010);

    // ---------------- continuous requests, single-beat reads ----------------
    do_reset();
`ifdef AXI_ARB_RR_EN
    seq_req = 3'b111;
`else
    seq_req = 3'b011;
`endif
    for (int m = 0; m < NM; m++) if (seq_req[m]) set_ar(m, AW'(16'h3000 + m), 8'd0, IW'(m));
    bus.s_arready = 1'b1;
    bus.m_rready = '1;
    for (int k = 0; k < 6; k++) begin
`ifdef AXI_ARB_RR_EN
      win = k % 3;
`else
      win = 0;
`endif
      #1;
      check("seq_idle_grant", bus.rd_grant, 0);
      check("seq_idle_s_arvalid", bus.s_arvalid, 0);
      tick();
      check("seq_grant", bus.rd_grant, 3'b001 << win);
      check("seq_s_arvalid", bus.s_arvalid, 1);
      tick();
      bus.s_rvalid = 1'b1;
      bus.s_rlast = 1'b1;
      #1;
      check("seq_m_rvalid", bus.m_rvalid, 3'b001 << win);
      tick();
      bus.s_rvalid = 1'b0;
      bus.s_rlast = 1'b0;
    end

    // ---------------- randomized read traffic vs owner model ----------------
    do_reset();
    own = -1;
    model_last = NM - 1;
    ar_done = 1'b0;
    sl_beats = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int m = 0; m < NM; m++)
        if (!bus.m_arvalid[m] && $urandom_range(0, 2) == 0)
          set_ar(m, AW'($urandom), 8'($urandom_range(0, 3)), IW'(m));
      bus.s_arready = 1'($urandom_range(0, 1));
      bus.m_rready = NM'($urandom);
      bus.s_rvalid = (sl_beats > 0) && ($urandom_range(0, 1) == 1);
      bus.s_rlast = (sl_beats == 1);
      bus.s_rdata = DW'($urandom);
      #1;
      exp_g = '0;
      if (own >= 0) exp_g[own] = 1'b1;
      check("rnd_rd_grant", bus.rd_grant, exp_g);
      check("rnd_m_arready", bus.m_arready, (own >= 0 && !ar_done && bus.s_arready) ? exp_g : '0);
      check("rnd_m_rvalid", bus.m_rvalid, (own >= 0 && ar_done && bus.s_rvalid) ? exp_g : '0);
      if (own >= 0) begin
        check("rnd_s_arvalid", bus.s_arvalid, !ar_done && bus.m_arvalid[own]);
        check("rnd_s_rready", bus.s_rready, ar_done && bus.m_rready[own]);
        if (!ar_done) begin
          check("rnd_s_araddr", bus.s_araddr, ar_addr[own]);
          check("rnd_s_arlen", bus.s_arlen, ar_len[own]);
        end
      end else begin
        check("rnd_s_arvalid_idle", bus.s_arvalid, 0);
        check("rnd_s_rready_idle", bus.s_rready, 0);
      end
      hs = bus.m_arvalid & bus.m_arready;
      accept = bus.s_arvalid && bus.s_arready;
      acc_len = bus.s_arlen;
      rhs = bus.s_rvalid && bus.s_rready;
      if (own < 0) begin
        if (|bus.m_arvalid) begin
          own = model_pick(bus.m_arvalid, model_last);
          model_last = own;
          ar_done = 1'b0;
        end
      end else if (!ar_done) begin
        if (bus.m_arvalid[own] && bus.s_arready) ar_done = 1'b1;
      end else if (bus.s_rvalid && bus.m_rready[own] && bus.s_rlast) begin
        own = -1;
      end
      tick();
      bus.m_arvalid = bus.m_arvalid & ~hs;
      if (rhs && sl_beats > 0) sl_beats--;
      if (accept) sl_beats = int'(acc_len) + 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
